secded_decoder_pipe: RTL and testbench
======================================

Name: secded_decoder_pipe

Overview:
- Pipelined SECDED decoder for the 32-bit Hamming path. It is the receive end of the Hamming encoder: it accepts a 39-bit codeword and returns corrected 32-bit data plus error flags.
- Valid/ready handshake on both sides, so it can sit between a memory or link and the consumer.
- Keeps saturating counts of corrected (SEC) and uncorrectable (DED) words for monitoring and self-test.

Parameters:
- CNT_W, 16, width of sec_count and ded_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  codeword valid.
- in_ready  output  1  decoder can accept a codeword this cycle.
- in_cw  input  39  codeword; in_cw[i] is Hamming position i (0..38).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  corrected data.
- out_sec  output  1  single error was corrected.
- out_ded  output  1  uncorrectable error; out_data is uncorrected.
- clr_counts  input  1  synchronous clear of both counters.
- sec_count  output  CNT_W  saturating SEC count.
- ded_count  output  CNT_W  saturating DED count.

Behaviour:
- Codeword layout:
  - Positions 1,2,4,8,16,32 are Hamming parity bits.
  - Data bits fill the remaining positions 3..38 in ascending order, so data[0]@3, data[1]@5, data[2]@6, ..., data[31]@38.
  - Position 0 is overall parity, chosen so that the XOR of all 39 bits is 0.
- Syndrome and overall parity:
  - s[5:0] = XOR of indices i (1..38) where cw[i]=1.
  - p = XOR of all 39 bits.
- Decode rules:
  - s=0, p=0: clean word; sec=0, ded=0.
  - p=1, s=0: error in bit 0 only; data unchanged; sec=1.
  - p=1, 1<=s<=38: flip cw[s], then extract data; sec=1.
  - p=1, s>38: ded=1; data extracted uncorrected.
  - s!=0, p=0: ded=1; data extracted uncorrected.
  - sec and ded are never both 1.
- Pipeline:
  - Stage 1 registers cw, s and p.
  - Stage 2 registers out_data, out_sec, out_ded and out_valid.
  - Latency is 2 cycles from the in handshake to out_valid with no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - Advance enable adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, both stages shift; stage-1 valid loads in_valid.
  - When adv=0, both stages hold.
  - Bubbles are not collapsed.
  - out_data/out_sec/out_ded stay stable while out_valid=1 and out_ready=0.
- Counters:
  - Increment on the output handshake (out_valid && out_ready): sec_count when out_sec=1, ded_count when out_ded=1.
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_counts has priority over a same-cycle increment; counts read 0 the next cycle.
- Reset:
  - Clears both stage valids, out_data=0, out_sec=0, out_ded=0, sec_count=0, ded_count=0.
  - Words in flight are discarded with no output and no count.
  - in_ready=1 in the first cycle after reset deasserts.

Optional Feature:
- Macro: SECDED_SYNDROME_LOG_EN.
- Defined: adds output last_syn (6 bits) and output last_err (1 bit).
  - On each output handshake with out_sec or out_ded set, last_syn loads that word's syndrome and last_err is set to 1.
  - Both are cleared by rst or clr_counts.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Clean word: in_cw=39'h55 (data 4), out_ready=1 -> out_valid 2 cycles later; out_data=32'd4, sec=0, ded=0; counts unchanged.
- Single error: in_cw=39'h15 (bit 6 flipped) -> out_data=4, out_sec=1; sec_count=1 after the handshake; last_syn=6 if SECDED_SYNDROME_LOG_EN. Repeat with bit 0 flipped (39'h54) -> data 4, sec=1.
- Double error: in_cw=39'h1D (bits 6 and 3 flipped) -> out_ded=1, out_sec=0, out_data=32'd1 (uncorrected); ded_count=1.
- Backpressure:
  - Stream 3 words with out_ready=0 from the first out_valid.
  - in_ready drops the same cycle; outputs hold stable.
  - Release out_ready -> all 3 words delivered in order, none lost or duplicated.
- Saturation and clear:
  - CNT_W=2: send 5 SEC words -> sec_count sticks at 3.
  - Assert clr_counts in the same cycle as a SEC handshake -> sec_count=0.
- Reset mid-stream: assert rst while 2 words are in flight -> out_valid=0 next cycle, no count change, in_ready=1 after release; the next word decodes normally.

Source files
------------

// File: rtl/secded_decoder_pipe.sv
// Two-stage SECDED decoder for the (39,32) Hamming code with valid/ready handshake
// and saturating SEC/DED counters. Define SECDED_SYNDROME_LOG_EN to add last_syn/last_err.
module secded_decoder_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [38:0]      in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_sec,
  output logic             out_ded,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
`ifdef SECDED_SYNDROME_LOG_EN
  ,
  output logic [5:0]       last_syn,
  output logic             last_err
`endif
);

  logic             adv;
  logic             out_hs;

  logic             s1_valid_q, s1_valid_d;
  logic [38:0]      s1_cw_q, s1_cw_d;
  logic [5:0]       s1_syn_q, s1_syn_d;
  logic             s1_par_q, s1_par_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_sec_q, out_sec_d;
  logic             out_ded_q, out_ded_d;

  logic [CNT_W-1:0] sec_count_q, sec_count_d;
  logic [CNT_W-1:0] ded_count_q, ded_count_d;

  logic [5:0]       syn_calc;
  logic [38:0]      cw_fix;
  logic [31:0]      data_fix;
  logic             dec_sec;
  logic             dec_ded;
  int unsigned      dbit;

`ifdef SECDED_SYNDROME_LOG_EN
  logic [5:0]       out_syn_q, out_syn_d;
  logic [5:0]       last_syn_q, last_syn_d;
  logic             last_err_q, last_err_d;
`endif

  assign adv    = !out_valid_q || out_ready;
  assign out_hs = out_valid_q && out_ready;

  // Stage 1 front end: syndrome and overall parity of the incoming word
  always_comb begin
    syn_calc = '0;
    for (int unsigned i = 1; i < 39; i++) begin
      if (in_cw[i]) syn_calc = syn_calc ^ 6'(i);
    end
  end

  // Stage 2 front end: correct and extract data from the registered word
  always_comb begin
    cw_fix   = s1_cw_q;
    dec_sec  = 1'b0;
    dec_ded  = 1'b0;
    data_fix = '0;
    dbit     = 0;
    if (s1_par_q) begin
      if (s1_syn_q == 6'd0) begin
        dec_sec = 1'b1;
      end else if (s1_syn_q <= 6'd38) begin
        dec_sec = 1'b1;
        for (int unsigned i = 1; i < 39; i++) begin
          if (s1_syn_q == 6'(i)) cw_fix[i] = ~s1_cw_q[i];
        end
      end else begin
        dec_ded = 1'b1;
      end
    end else if (s1_syn_q != 6'd0) begin
      dec_ded = 1'b1;
    end
    for (int unsigned i = 3; i < 39; i++) begin
      if ((i & (i - 1)) != 0) begin
        data_fix[dbit] = cw_fix[i];
        dbit           = dbit + 1;
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cw_d     = s1_cw_q;
    s1_syn_d    = s1_syn_q;
    s1_par_d    = s1_par_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sec_d   = out_sec_q;
    out_ded_d   = out_ded_q;
`ifdef SECDED_SYNDROME_LOG_EN
    out_syn_d   = out_syn_q;
`endif
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_cw_d     = in_cw;
      s1_syn_d    = syn_calc;
      s1_par_d    = ^in_cw;
      out_valid_d = s1_valid_q;
      out_data_d  = data_fix;
      out_sec_d   = dec_sec;
      out_ded_d   = dec_ded;
`ifdef SECDED_SYNDROME_LOG_EN
      out_syn_d   = s1_syn_q;
`endif
    end
  end

  // Counters and log: clear beats a same-cycle handshake
  always_comb begin
    sec_count_d = sec_count_q;
    ded_count_d = ded_count_q;
    if (clr_counts) begin
      sec_count_d = '0;
      ded_count_d = '0;
    end else if (out_hs) begin
      if (out_sec_q && sec_count_q != '1) sec_count_d = sec_count_q + 1'b1;
      if (out_ded_q && ded_count_q != '1) ded_count_d = ded_count_q + 1'b1;
    end
`ifdef SECDED_SYNDROME_LOG_EN
    last_syn_d = last_syn_q;
    last_err_d = last_err_q;
    if (clr_counts) begin
      last_syn_d = '0;
      last_err_d = 1'b0;
    end else if (out_hs && (out_sec_q || out_ded_q)) begin
      last_syn_d = out_syn_q;
      last_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      sec_count_q <= '0;
      ded_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
    end
  end

`ifdef SECDED_SYNDROME_LOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_syn_q  <= '0;
      last_syn_q <= '0;
      last_err_q <= 1'b0;
    end else begin
      out_syn_q  <= out_syn_d;
      last_syn_q <= last_syn_d;
      last_err_q <= last_err_d;
    end
  end

  assign last_syn = last_syn_q;
  assign last_err = last_err_q;
`endif

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign sec_count = sec_count_q;
  assign ded_count = ded_count_q;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed, table-driven bench for secded_decoder_pipe (CNT_W=2 to reach saturation quickly).
module tb_secded_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [38:0] in_cw;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sec;
  logic        out_ded;
  logic        clr_counts;
  logic [1:0]  sec_count;
  logic [1:0]  ded_count;
`ifdef SECDED_SYNDROME_LOG_EN
  logic [5:0]  last_syn;
  logic        last_err;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  secded_decoder_pipe #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cw      (in_cw),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sec    (out_sec),
    .out_ded    (out_ded),
    .clr_counts (clr_counts),
    .sec_count  (sec_count),
    .ded_count  (ded_count)
`ifdef SECDED_SYNDROME_LOG_EN
    ,
    .last_syn   (last_syn),
    .last_err   (last_err)
`endif
  );

  typedef struct {
    string       name;
    logic [38:0] cw;
    logic [31:0] data;
    logic        sec;
    logic        ded;
    logic [5:0]  syn;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
  endtask

  task automatic send_one(input string nm, input logic [38:0] cw, input logic [31:0] d,
                          input logic sec, input logic ded, input int unsigned esc,
                          input int unsigned edc, input logic [5:0] lsyn, input logic lerr);
    int unsigned lat;
    @(negedge clk);
    check({nm, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_cw    = cw;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'd2);
    check({nm, " data"}, 64'(out_data), 64'(d));
    check({nm, " sec"}, 64'(out_sec), 64'(sec));
    check({nm, " ded"}, 64'(out_ded), 64'(ded));
    @(negedge clk);
    check({nm, " sec_count"}, 64'(sec_count), 64'(esc));
    check({nm, " ded_count"}, 64'(ded_count), 64'(edc));
`ifdef SECDED_SYNDROME_LOG_EN
    check({nm, " last_syn"}, 64'(last_syn), 64'(lsyn));
    check({nm, " last_err"}, 64'(last_err), 64'(lerr));
`else
    if (lerr && lsyn == 6'd63) check({nm, " log args"}, 64'(lsyn), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got[$];
    logic [31:0] exp_bp[3];
    logic [38:0] cw_bp[3];
    int unsigned budget;

    vecs[0] = '{"clean4",  39'h00_0000_0055, 32'h0000_0004, 1'b0, 1'b0, 6'd0};
    vecs[1] = '{"sec_b6",  39'h00_0000_0015, 32'h0000_0004, 1'b1, 1'b0, 6'd6};
    vecs[2] = '{"sec_b0",  39'h00_0000_0054, 32'h0000_0004, 1'b1, 1'b0, 6'd0};
    vecs[3] = '{"ded_b63", 39'h00_0000_001D, 32'h0000_0001, 1'b0, 1'b1, 6'd5};
    vecs[4] = '{"zero",    39'h00_0000_0000, 32'h0000_0000, 1'b0, 1'b0, 6'd0};
    vecs[5] = '{"ones",    39'h7E_FFFF_FFE8, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd0};
    vecs[6] = '{"sec_b38", 39'h3E_FFFF_FFE8, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'd38};
    vecs[7] = '{"ded_3738",39'h1E_FFFF_FFE8, 32'h3FFF_FFFF, 1'b0, 1'b1, 6'd3};
    vecs[8] = '{"ded_s49", 39'h01_0001_0002, 32'h0000_0000, 1'b0, 1'b1, 6'd49};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_cw      = '0;
    out_ready  = 1'b1;
    clr_counts = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_sec", 64'(out_sec), 64'd0);
    check("rst out_ded", 64'(out_ded), 64'd0);
    check("rst sec_count", 64'(sec_count), 64'd0);
    check("rst ded_count", 64'(ded_count), 64'd0);

    for (int i = 0; i < 9; i++) begin
      clear_counts();
      send_one(vecs[i].name, vecs[i].cw, vecs[i].data, vecs[i].sec, vecs[i].ded,
               vecs[i].sec ? 1 : 0, vecs[i].ded ? 1 : 0,
               (vecs[i].sec || vecs[i].ded) ? vecs[i].syn : 6'd0, vecs[i].sec || vecs[i].ded);
    end

    // Backpressure: three words queued behind a stalled consumer
    clear_counts();
    cw_bp[0] = 39'h00_0000_0055; exp_bp[0] = 32'h0000_0004;
    cw_bp[1] = 39'h7E_FFFF_FFE8; exp_bp[1] = 32'hFFFF_FFFF;
    cw_bp[2] = 39'h00_0000_001D; exp_bp[2] = 32'h0000_0001;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp in_ready w0", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_cw = cw_bp[0];
    @(negedge clk);
    check("bp in_ready w1", 64'(in_ready), 64'd1);
    in_cw = cw_bp[1];
    @(negedge clk);
    check("bp out_valid", 64'(out_valid), 64'd1);
    check("bp in_ready drop", 64'(in_ready), 64'd0);
    in_cw = cw_bp[2];
    repeat (3) begin
      @(negedge clk);
      check("bp hold valid", 64'(out_valid), 64'd1);
      check("bp hold data", 64'(out_data), 64'(exp_bp[0]));
      check("bp hold ded", 64'(out_ded), 64'd0);
      check("bp hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 64'(in_ready), 64'd1);
    if (out_valid) got.push_back(out_data);
    @(negedge clk);
    in_valid = 1'b0;
    budget = 0;
    while (got.size() < 4 && budget < 6) begin
      if (out_valid) got.push_back(out_data);
      @(negedge clk);
      budget++;
    end
    check("bp word count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) check("bp order", 64'(got[k]), 64'(exp_bp[k]));
      else check("bp missing", 64'd0, 64'(exp_bp[k]) | 64'h1_0000_0000);
    end
    check("bp ded_count", 64'(ded_count), 64'd1);

    // Saturation of a 2-bit counter
    clear_counts();
    for (int k = 1; k <= 5; k++) begin
      send_one("sat", 39'h00_0000_0015, 32'h0000_0004, 1'b1, 1'b0,
               (k > 3) ? 3 : k, 0, 6'd6, 1'b1);
    end

    // Clear in the same cycle as a SEC handshake
    @(negedge clk);
    in_valid = 1'b1; in_cw = 39'h00_0000_0015;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr out_valid", 64'(out_valid), 64'd1);
    check("clr pre count", 64'(sec_count), 64'd3);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    check("clr sec_count", 64'(sec_count), 64'd0);
`ifdef SECDED_SYNDROME_LOG_EN
    check("clr last_err", 64'(last_err), 64'd0);
`endif

    // Reset with two words in flight
    @(negedge clk);
    in_valid = 1'b1; in_cw = 39'h00_0000_0015;
    @(negedge clk);
    in_cw = 39'h00_0000_001D;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst sec_count", 64'(sec_count), 64'd0);
    check("mid rst ded_count", 64'(ded_count), 64'd0);
    check("mid rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("mid rst no ghost", 64'(out_valid), 64'd0);
    send_one("post_rst", 39'h00_0000_0055, 32'h0000_0004, 1'b0, 1'b0, 0, 0, 6'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
